// File: rtl/therm_pkg.sv
// therm_pkg: shared sizes and FSM state encoding for the thermometer ramp decoder
package therm_pkg;
    localparam int N_LINES = 15;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} ramp_state_t;
endpackage

// File: rtl/therm_decode.sv
// therm_decode: combinational count to thermometer conversion, therm[i] = (i < count)
// ports: count (W-bit population count in), therm (N-bit thermometer out)
module therm_decode #(
    parameter int N = 15,
    parameter int W = 4
) (
    input  logic [W-1:0] count,
    output logic [N-1:0] therm
);
    for (genvar g = 0; g < N; g++) begin : gen_bit
        assign therm[g] = count > W'(g);
    end
endmodule

// File: rtl/therm_ramp_decoder.sv
// therm_ramp_decoder: accepts a target count and ramps a thermometer bank toward it one line per clock
// ports: clk, rst (async, active-high); in_valid/in_ready/code handshake for the target;
//        lines (registered thermometer), count (lines currently high), busy (ramping), done (one-cycle pulse)
module therm_ramp_decoder
    import therm_pkg::*;
#(
    parameter int N = N_LINES,
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] code,
    output logic [N-1:0] lines,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         done
);
    localparam logic [W:0] MAX = (W+1)'(N);
    ramp_state_t state, state_n;
    logic [W-1:0] target, target_n, count_n, code_sat;
    logic [W:0] code_x;
    logic [N-1:0] lines_n;
    // compare in one extra bit so the clamp stays meaningful when N < 2**W - 1
    assign code_x = {1'b0, code};
    assign code_sat = code_x > MAX ? W'(N) : code;
    always_comb begin
        state_n = state;
        target_n = target;
        count_n = count;
        case (state)
            IDLE: if (in_valid) begin
                target_n = code_sat;
                state_n = code_sat > count ? UP : code_sat < count ? DOWN : DONE;
            end
            UP: begin
                count_n = count + 1'b1;
                state_n = count_n == target ? DONE : UP;
            end
            DOWN: begin
                count_n = count - 1'b1;
                state_n = count_n == target ? DONE : DOWN;
            end
            default: state_n = IDLE;
        endcase
    end
    // lines is the registered decode of the next count, so it can never hold a non-thermometer pattern
    therm_decode #(.N(N), .W(W)) u_dec (.count(count_n), .therm(lines_n));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            target <= '0;
            count <= '0;
            lines <= '0;
        end else begin
            state <= state_n;
            target <= target_n;
            count <= count_n;
            lines <= lines_n;
        end
    end
    assign in_ready = state == IDLE;
    assign busy = state == UP || state == DOWN;
    assign done = state == DONE;
endmodule

// File: tb/tb_therm_ramp_decoder.sv
// tb_therm_ramp_decoder: directed table, ignore/reset corner sequences and random ramps for therm_ramp_decoder
module tb_therm_ramp_decoder;
    import therm_pkg::*;
    localparam int N = N_LINES;
    localparam int W = CNT_W;
    typedef struct {
        int c;
        bit noise;
        logic [N-1:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [W-1:0] code = '0;
    logic in_ready, busy, done;
    logic [N-1:0] lines, ref_lines;
    logic [N-1:0] prev_lines = '0;
    logic [W-1:0] count;
    int total = 0;
    int bad = 0;
    int mc = 0;
    bit check_en = 1'b0;
    vec_t vt[8];
    always #5 clk = ~clk;
    therm_ramp_decoder #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .code(code),
        .lines(lines), .count(count), .busy(busy), .done(done)
    );
    therm_decode #(.N(N), .W(W)) ref_dec (.count(count), .therm(ref_lines));
    function automatic logic [N-1:0] therm(input int c);
        logic [31:0] t;
        t = (32'd1 << c) - 32'd1;
        return t[N-1:0];
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic tick();
        @(negedge clk);
        if (check_en) begin
            check("therm_consistent", 32'(lines), 32'(ref_lines));
            check("hamming_le1", 32'($countones(lines ^ prev_lines) <= 1), 32'd1);
        end
        prev_lines = lines;
    endtask
    task automatic apply(input int c, input bit noise, input logic [N-1:0] exp_final);
        int tgt, d, stp;
        tgt = c > N ? N : c;
        d = tgt > mc ? tgt - mc : mc - tgt;
        stp = tgt > mc ? 1 : -1;
        check("ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        code = W'(c);
        tick();
        in_valid = 1'b0;
        if (d == 0) begin
            check("done_equal", 32'(done), 32'd1);
            check("lines_held", 32'(lines), 32'(therm(mc)));
        end else begin
            check("busy_after_accept", 32'(busy), 32'd1);
            check("no_early_done", 32'(done), 32'd0);
            check("not_ready_busy", 32'(in_ready), 32'd0);
        end
        for (int j = 1; j <= d; j++) begin
            if (noise) begin
                in_valid = j[0];
                code = '0;
            end
            tick();
            mc += stp;
            check("count_step", 32'(count), 32'(mc));
            check("lines_step", 32'(lines), 32'(therm(mc)));
            check("done_timing", 32'(done), 32'(j == d));
        end
        in_valid = 1'b0;
        tick();
        check("done_cleared", 32'(done), 32'd0);
        check("ready_back", 32'(in_ready), 32'd1);
        check("final_lines", 32'(lines), 32'(exp_final));
    endtask
    initial begin
        vt[0] = '{5, 1'b0, 15'h001F};
        vt[1] = '{2, 1'b0, 15'h0003};
        vt[2] = '{2, 1'b0, 15'h0003};
        vt[3] = '{0, 1'b0, 15'h0000};
        vt[4] = '{15, 1'b1, 15'h7FFF};
        vt[5] = '{9, 1'b0, 15'h01FF};
        vt[6] = '{9, 1'b0, 15'h01FF};
        vt[7] = '{1, 1'b0, 15'h0001};
        repeat (3) tick();
        check("rst_lines", 32'(lines), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();
        check_en = 1'b1;
        foreach (vt[i]) apply(vt[i].c, vt[i].noise, vt[i].exp);
        apply(0, 1'b0, 15'h0000);
        in_valid = 1'b1;
        code = 4'd15;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("mid_ramp_lines", 32'(lines), 32'h007F);
        check_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_lines", 32'(lines), 32'h0);
        check("async_count", 32'(count), 32'h0);
        check("async_ready", 32'(in_ready), 32'd1);
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        mc = 0;
        tick();
        check_en = 1'b1;
        apply(3, 1'b0, 15'h0007);
        for (int n = 0; n < 1000; n++) begin
            int c;
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("idle_ready", 32'(in_ready), 32'd1);
            end
            c = $urandom_range(0, 15);
            apply(c, 1'($urandom_range(0, 1)), therm(c));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/therm_ramp_decoder.md
# therm_ramp_decoder

Sequential thermometer decoder: the inverse of the team's 15-input ones-counter, which reduces 15 independent lines to a 4-bit population count. This block accepts a 4-bit target count through a valid/ready handshake. It then drives 15 output lines toward the matching thermometer pattern (lines[i] = 1 iff i < count), moving exactly one line per clock. It sits downstream of the counter and drives line-level stimulus or actuator banks that must never change more than one line per cycle.

## Interface
- N, 15, number of output lines.
- W, 4, code/count width; must equal $clog2(N+1).

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  code is valid this cycle.
- in_ready  output  1  block can accept a code; high only in IDLE.
- code  input  W  target count; values > N saturate to N.
- lines  output  N  thermometer output, registered.
- count  output  W  number of lines currently high, registered.
- busy  output  1  high in UP or DOWN.
- done  output  1  one-cycle pulse when lines first equal target.

## Operation
- States: IDLE, UP, DOWN, DONE. Encoding comes from the package.
- Reset state:
  - state = IDLE, count = 0, lines = 0.
  - in_ready = 1, busy = 0, done = 0.
- IDLE: on in_valid && in_ready, latch target = min(code, N).
  - target > count → UP.
  - target < count → DOWN.
  - target == count → DONE.
- UP: each edge count += 1 and lines[count] sets. When the new count == target → DONE.
- DOWN: each edge count −= 1 and lines[count−1] clears. When the new count == target → DONE.
- DONE: done = 1 for exactly this one cycle, then → IDLE unconditionally.
- in_valid while not IDLE is ignored. No queuing, and target is not updated.
- The block never leaves an intermediate thermometer state. lines always equals the thermometer of count; no other pattern is legal.
- Saturation: a code above N is clamped before comparison. With N=15, W=4 no clamp is reachable, but the clamp logic is required for generic N.
- count never wraps: it stays within 0..N in all states.

## Timing
- Acceptance is at edge k (in_valid && in_ready sampled high).
- For d = |target − count|:
  - With d > 0, lines change at edges k+1 … k+d. done is high in the cycle after edge k+d. in_ready returns high one cycle later (after edge k+d+1).
  - With d = 0, done is high in the cycle after edge k. lines and count are unchanged.
- Throughput is one code per d+2 cycles minimum (d+1 acceptance-to-done plus the DONE cycle).
- Every output is registered and there is no combinational path from in_valid or code to any output.
- Hamming distance between consecutive lines values is ≤ 1 on every edge.
- Asserting rst at any time, including mid-ramp or during DONE, clears lines, count and done and returns to IDLE immediately, without waiting for clk. The first acceptance after deassertion ramps from 0.

## Structure
- Package therm_pkg holds:
  - localparams N_LINES = 15 and CNT_W = 4.
  - typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} ramp_state_t.
- One sub-module, therm_decode, converts a W-bit count to an N-bit thermometer. It is combinational and parameterised by N and W. The top registers its output (or updates lines incrementally), and the bench also reuses it as a reference model.
- The top contains the FSM, the target/count registers and the handshake.

## Test plan
- Reset: assert rst for 3 cycles → lines = 15'h0000, count = 0, in_ready = 1, busy = 0, done = 0.
- Ramp up: from 0, present code = 5 for one cycle → lines = 0001, 0003, 0007, 000F, 001F on successive edges. done pulses once in the following cycle, in_ready returns the cycle after that.
- Ramp down then equal: from 5, code = 2 → 000F, 0007, 0003 then done. Next, code = 2 → done the cycle after acceptance with lines held at 0003.
- Full scale and ignore: from 0, code = 15 → 15 single-bit steps ending at 7FFF. Toggle in_valid with code = 0 throughout the ramp → no effect on target. A checker flags any step with Hamming distance > 1.
- Async reset mid-ramp: from 0, code = 15, assert rst after 7 steps (lines = 007F) between clock edges → lines = 0000 and state IDLE before the next edge. After release, code = 3 ramps from 0 to 0007.
- Random regression: 1000 random codes with random in_valid gaps → lines == therm_decode(count) every cycle, and count == the last accepted target whenever done = 1.
